// File: rtl/not_share_arbiter.sv
// Round-robin arbiter that time-shares one external single-bit inverter among N requesters,
// returning each inverted operand with a one-cycle strobe and flagging a sticky inverter fault.
module not_share_arbiter #(
    parameter int N      = 4,
    parameter int IDX_W  = 2,
    parameter int SETTLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     req_bit,
    output logic             not_in,
    input  logic             not_out,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     rsp_valid,
    output logic             rsp_bit,
    output logic             busy,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [N-1:0]     rsp_valid_q, rsp_valid_d;
    logic             not_in_q, not_in_d;
    logic             rsp_bit_q, rsp_bit_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W:0]   pick_s;

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    // Search ptr+1, ptr+2, ... modulo N; iterating from the far end lets the nearest hit win.
    function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] req_v, input logic [IDX_W-1:0] ptr_v);
        logic [IDX_W:0] res;
        logic [IDX_W:0] sum;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_v} + (IDX_W+1)'(k + 1);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end else begin
                sum = sum;
            end
            if (req_v[sum[IDX_W-1:0]]) begin
                res = {1'b1, sum[IDX_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin winner for the current request vector.
    always_comb begin
        pick_s = rr_pick(req, ptr_q);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rsp_valid_d = {N{1'b0}};
        not_in_d    = not_in_q;
        rsp_bit_d   = rsp_bit_q;
        busy_d      = busy_q;
        fault_d     = fault_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_s[IDX_W]) begin
                    grant_d  = onehot(pick_s[IDX_W-1:0]);
                    not_in_d = req_bit[pick_s[IDX_W-1:0]];
                    idx_d    = pick_s[IDX_W-1:0];
                    cnt_d    = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = DRIVE;
                end else begin
                    grant_d  = {N{1'b0}};
                    not_in_d = 1'b0;
                    busy_d   = 1'b0;
                    cnt_d    = 4'd0;
                    state_d  = IDLE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SETTLE - 1)) begin
                    rsp_bit_d   = not_out;
                    rsp_valid_d = onehot(idx_q);
                    // A healthy inverter never returns its own input.
                    fault_d     = fault_q | (not_out == not_in_q);
                    ptr_d       = idx_q;
                    state_d     = DONE;
                end else begin
                    state_d = DRIVE;
                end
            end
            DONE: begin
                grant_d   = {N{1'b0}};
                not_in_d  = 1'b0;
                rsp_bit_d = 1'b0;
                busy_d    = 1'b0;
                cnt_d     = 4'd0;
                state_d   = IDLE;
            end
            default: begin
                grant_d   = {N{1'b0}};
                not_in_d  = 1'b0;
                rsp_bit_d = 1'b0;
                busy_d    = 1'b0;
                cnt_d     = 4'd0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= {N{1'b0}};
            rsp_valid_q <= {N{1'b0}};
            not_in_q    <= 1'b0;
            rsp_bit_q   <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            idx_q       <= {IDX_W{1'b0}};
            ptr_q       <= IDX_W'(N - 1);
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rsp_valid_q <= rsp_valid_d;
            not_in_q    <= not_in_d;
            rsp_bit_q   <= rsp_bit_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign rsp_valid = rsp_valid_q;
    assign not_in    = not_in_q;
    assign rsp_bit   = rsp_bit_q;
    assign busy      = busy_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_not_share_arbiter.sv
// Self-checking bench: two arbiters (SETTLE=1 and SETTLE=3) against a cycle-count transaction model.
module tb_not_share_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_bit;
    logic       stuck;

    logic       not_in_a, not_out_a, rsp_bit_a, busy_a, fault_a;
    logic [3:0] grant_a, rsp_valid_a;
    logic       not_in_b, not_out_b, rsp_bit_b, busy_b, fault_b;
    logic [3:0] grant_b, rsp_valid_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // transaction model state, index 0 -> SETTLE=1 instance, index 1 -> SETTLE=3 instance
    bit         act [2];
    int         e0  [2];
    int         win [2];
    int         ptr [2];
    bit         opnd[2];
    bit         flt [2];
    bit         rb  [2];
    logic [3:0] x_grant[2];
    logic [3:0] x_rv   [2];
    logic [3:0] x_nin  [2];
    logic [3:0] x_busy [2];
    logic [3:0] x_flt  [2];
    logic [3:0] x_rb   [2];

    assign not_out_a = stuck ? not_in_a : ~not_in_a;
    assign not_out_b = stuck ? not_in_b : ~not_in_b;

    not_share_arbiter #(.N(4), .IDX_W(2), .SETTLE(1)) dut_a (
        .clock(clock), .reset(reset), .req(req), .req_bit(req_bit),
        .not_in(not_in_a), .not_out(not_out_a), .grant(grant_a),
        .rsp_valid(rsp_valid_a), .rsp_bit(rsp_bit_a), .busy(busy_a), .fault(fault_a)
    );

    not_share_arbiter #(.N(4), .IDX_W(2), .SETTLE(3)) dut_b (
        .clock(clock), .reset(reset), .req(req), .req_bit(req_bit),
        .not_in(not_in_b), .not_out(not_out_b), .grant(grant_b),
        .rsp_valid(rsp_valid_b), .rsp_bit(rsp_bit_b), .busy(busy_b), .fault(fault_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        int q;
        for (int k = 1; k <= 4; k++) begin
            q = (p + k) % 4;
            if (r[q[1:0]]) return q;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update();
        int s;
        int w;
        for (int i = 0; i < 2; i++) begin
            s = settle_of(i);
            if (reset) begin
                act[i] = 1'b0;
                ptr[i] = 3;
                flt[i] = 1'b0;
            end else if (!act[i] || cyc >= e0[i] + s + 2) begin
                act[i] = 1'b0;
                w = pick(req, ptr[i]);
                if (w >= 0) begin
                    act[i]  = 1'b1;
                    e0[i]   = cyc;
                    win[i]  = w;
                    opnd[i] = req_bit[w[1:0]];
                end
            end else if (cyc == e0[i] + s) begin
                ptr[i] = win[i];
                flt[i] = flt[i] | stuck;
                rb[i]  = stuck ? opnd[i] : !opnd[i];
            end
            if (act[i] && cyc <= e0[i] + s) begin
                x_grant[i] = 4'b0001 << win[i];
                x_busy[i]  = 4'd1;
                x_nin[i]   = {3'b000, opnd[i]};
                x_rv[i]    = (cyc == e0[i] + s) ? (4'b0001 << win[i]) : 4'd0;
            end else begin
                x_grant[i] = 4'd0;
                x_busy[i]  = 4'd0;
                x_nin[i]   = 4'd0;
                x_rv[i]    = 4'd0;
            end
            x_flt[i] = {3'b000, flt[i]};
            x_rb[i]  = {3'b000, rb[i]};
        end
    endtask

    task automatic check_all();
        chk("a.grant", grant_a, x_grant[0]);
        chk("a.rsp_valid", rsp_valid_a, x_rv[0]);
        chk("a.not_in", {3'b000, not_in_a}, x_nin[0]);
        chk("a.busy", {3'b000, busy_a}, x_busy[0]);
        chk("a.fault", {3'b000, fault_a}, x_flt[0]);
        if (x_rv[0] != 4'd0) chk("a.rsp_bit", {3'b000, rsp_bit_a}, x_rb[0]);
        chk("b.grant", grant_b, x_grant[1]);
        chk("b.rsp_valid", rsp_valid_b, x_rv[1]);
        chk("b.not_in", {3'b000, not_in_b}, x_nin[1]);
        chk("b.busy", {3'b000, busy_b}, x_busy[1]);
        chk("b.fault", {3'b000, fault_b}, x_flt[1]);
        if (x_rv[1] != 4'd0) chk("b.rsp_bit", {3'b000, rsp_bit_b}, x_rb[1]);
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'd0;
        req_bit = 4'd0;
        stuck   = 1'b0;
        step();
        step();

        // single request, SETTLE=1 latency
        reset   = 1'b0;
        req     = 4'b0001;
        req_bit = 4'b0001;
        step();
        chk("d.first_grant", grant_a, 4'b0001);
        chk("d.first_not_in", {3'b000, not_in_a}, 4'd1);
        req = 4'b0000;
        step();
        chk("d.first_rsp_valid", rsp_valid_a, 4'b0001);
        chk("d.first_rsp_bit", {3'b000, rsp_bit_a}, 4'd0);
        step();
        chk("d.first_release", grant_a, 4'b0000);
        chk("d.first_fault", {3'b000, fault_a}, 4'd0);
        repeat (3) step();

        // all requesting, operands zero: strict rotation
        req     = 4'b1111;
        req_bit = 4'b0000;
        step();
        chk("d.rr_next", grant_a, 4'b0010);
        repeat (16) step();

        // wrap-around with sparse requests
        req = 4'b0101;
        repeat (12) step();

        // operand toggling while driving
        for (int i = 0; i < 30; i++) begin
            req     = 4'($urandom);
            req_bit = 4'($urandom);
            step();
        end

        // stuck inverter: fault is sticky until reset
        req   = 4'b0000;
        repeat (6) step();
        stuck = 1'b1;
        req   = 4'b0001;
        repeat (6) step();
        chk("d.fault_set", {3'b000, fault_a}, 4'd1);
        stuck = 1'b0;
        req   = 4'b1111;
        repeat (20) step();
        chk("d.fault_sticky", {3'b000, fault_b}, 4'd1);
        reset = 1'b1;
        step();
        chk("d.fault_clear", {3'b000, fault_a}, 4'd0);

        // reset during DRIVE aborts silently and rewinds the pointer
        reset = 1'b0;
        req   = 4'b1000;
        step();
        req   = 4'b0000;
        reset = 1'b1;
        step();
        chk("d.abort_grant", grant_a, 4'b0000);
        chk("d.abort_busy", {3'b000, busy_a}, 4'd0);
        chk("d.abort_rsp", rsp_valid_a, 4'b0000);
        reset = 1'b0;
        req   = 4'b0010;
        step();
        chk("d.post_reset_grant", grant_a, 4'b0010);
        repeat (5) step();

        // random soak
        for (int i = 0; i < 400; i++) begin
            req     = 4'($urandom);
            req_bit = 4'($urandom);
            stuck   = ($urandom_range(0, 9) == 0);
            reset   = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/not_share_arbiter.md
Name: not_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external single-bit inverter instance (myNot) among N requesters.
- Grants one requester at a time, drives that requester's operand onto the inverter input and holds it for a settle window.
- Samples the inverter output and returns the result to the granted requester with a one-cycle valid pulse.
- Checks each result against the expected inversion and flags a sticky fault; sits between user logic and the shared myNot on the Elbert V2 design.

Parameters:
- N, 4, number of requesters (2..8).
- IDX_W, 2, index width; must equal clog2(N).
- SETTLE, 1, cycles the operand is held on not_in before sampling (min 1, max 15).

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level.
- req_bit  in  N  per-requester operand bit.
- not_in  out  1  operand driven to shared inverter input.
- not_out  in  1  shared inverter output.
- grant  out  N  one-hot grant, zero when idle.
- rsp_valid  out  N  one-hot, one-cycle result strobe.
- rsp_bit  out  1  result bit, valid while any rsp_valid bit is high.
- busy  out  1  high in DRIVE and DONE.
- fault  out  1  sticky: sampled not_out equalled not_in.

Behaviour:
- One clock; reset is synchronous and active-high (ports clock, reset).
- Reset values:
  - state=IDLE; grant=0, rsp_valid=0, rsp_bit=0, not_in=0, busy=0, fault=0.
  - Settle counter=0.
  - Last-grant pointer ptr=N-1, so requester 0 wins first.
- States: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE:
  - If req!=0, select the first set bit searching ptr+1, ptr+2, ... with wrap modulo N.
  - Register grant=onehot(sel), not_in=req_bit[sel], idx=sel, cnt=0; go to DRIVE.
  - Otherwise stay in IDLE with outputs low.
- DRIVE:
  - grant and not_in are held constant; cnt increments each cycle.
  - In the cycle with cnt==SETTLE-1, at the edge:
    - rsp_bit<=not_out.
    - rsp_valid<=onehot(idx).
    - fault<=fault | (not_out==not_in).
    - ptr<=idx.
    - state<=DONE.
- DONE:
  - One cycle with rsp_valid, grant and busy high.
  - Next edge: grant=0, rsp_valid=0, not_in=0, state=IDLE.
- Latency: req sampled in IDLE at edge t → grant high from t+1 → rsp_valid high in cycle t+SETTLE+1 → back to IDLE at t+SETTLE+2.
  - One operation per SETTLE+2 cycles.
  - IDLE always lasts at least one cycle between operations.
- Operand is latched at grant. Changes on req_bit[idx] during DRIVE are ignored.
- Requester drops req mid-operation: the operation still completes and rsp_valid still pulses; no abort.
- Requester holding req continuously: it is re-eligible only after all other active requesters are served (strict round robin).
- Simultaneous requests: winner is determined solely by the ptr search order.
- New req arriving during DRIVE/DONE waits for IDLE.
- Reset asserted mid-operation: immediate return to reset values at that edge; no rsp_valid is emitted for the aborted operation.
- fault is cleared only by reset.

Test Plan:
- Reset, then req=0001 with req_bit[0]=1, SETTLE=1, not_out tied to ~not_in:
  - grant=0001 at t+1, not_in=1.
  - rsp_valid=0001 with rsp_bit=0 at t+2.
  - grant=0 at t+3; fault=0.
- req=1111 held constant, all operands 0:
  - grants sequence 0001, 0010, 0100, 1000, 0001, each 3 cycles apart.
  - Each rsp_bit=1.
- After requester 2 is served, req=0101:
  - next grant=0100? no: ptr=2, so the next grant=0001, then 0100.
  - Verify wrap-around order.
- SETTLE=3, req_bit toggled during DRIVE:
  - not_in stays at the latched value for 3 cycles.
  - rsp_valid appears exactly 4 cycles after the IDLE sample.
- not_out stuck equal to not_in: fault rises with the first rsp_valid, stays 1 through later clean operations, and clears only on reset.
- Reset pulsed in the DRIVE cycle:
  - next cycle grant=0, busy=0, no rsp_valid.
  - With req=0010 pending afterwards, the first grant after reset is 0010 (ptr back to N-1).
